// File: rtl/sub_abs_pipe_if.sv
// rtl/sub_abs_pipe_if.sv - operand/result handshake bundle for sub_abs_pipe
interface sub_abs_pipe_if #(parameter int width = 74);
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] in1;
    logic [width-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] res;
    logic             swap;
    logic             zero;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, res, swap, zero
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, res, swap, zero
    );
endinterface

// File: rtl/sub_abs_pipe.sv
// rtl/sub_abs_pipe.sv - two-stage pipelined |in1 - in2| with larger-operand flag
module sub_abs_pipe #(
    parameter int width = 74
) (
    input  logic         clk,
    input  logic         rst,
    sub_abs_pipe_if.slave bus
);
    localparam int L = width / 2;
    localparam int H = width - L;

    logic             s1_v, s2_v;
    logic             s1_adv, s2_adv;

    logic [L-1:0]     s1_a_lo, s1_b_lo;
    logic             s1_ca, s1_cb;
    logic [H-1:0]     s1_in1_hi, s1_in2_hi;

    logic [L:0]       a_lo_sum, b_lo_sum;
    logic [H:0]       a_hi_sum;
    logic [H-1:0]     b_hi;
    logic [width-1:0] diff_a, diff_b;
    logic             borrow;

    logic [width-1:0] res_q;
    logic             swap_q, zero_q;

    assign s2_adv       = !s2_v || bus.out_ready;
    assign s1_adv       = !s1_v || s2_adv;
    assign bus.in_ready = s1_adv;

    // Both directions run side by side as x + ~y + 1; the low-half carries feed stage 2.
    assign a_lo_sum = {1'b0, bus.in1[L-1:0]} + {1'b0, ~bus.in2[L-1:0]} + (L+1)'(1'b1);
    assign b_lo_sum = {1'b0, bus.in2[L-1:0]} + {1'b0, ~bus.in1[L-1:0]} + (L+1)'(1'b1);

    assign a_hi_sum = {1'b0, s1_in1_hi} + {1'b0, ~s1_in2_hi} + (H+1)'(s1_ca);
    assign b_hi     = s1_in2_hi + ~s1_in1_hi + H'(s1_cb);

    assign diff_a = {a_hi_sum[H-1:0], s1_a_lo};
    assign diff_b = {b_hi, s1_b_lo};
    assign borrow = ~a_hi_sum[H];

    assign bus.out_valid = s2_v;
    assign bus.res       = res_q;
    assign bus.swap      = swap_q;
    assign bus.zero      = zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_a_lo   <= '0;
            s1_b_lo   <= '0;
            s1_ca     <= 1'b0;
            s1_cb     <= 1'b0;
            s1_in1_hi <= '0;
            s1_in2_hi <= '0;
        end else if (s1_adv) begin
            s1_v <= bus.in_valid;
            // Payload only moves on a real transfer so bubbles keep old values.
            if (bus.in_valid) begin
                s1_a_lo   <= a_lo_sum[L-1:0];
                s1_b_lo   <= b_lo_sum[L-1:0];
                s1_ca     <= a_lo_sum[L];
                s1_cb     <= b_lo_sum[L];
                s1_in1_hi <= bus.in1[width-1:L];
                s1_in2_hi <= bus.in2[width-1:L];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v   <= 1'b0;
            res_q  <= '0;
            swap_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                res_q  <= borrow ? diff_b : diff_a;
                swap_q <= borrow;
                zero_q <= (diff_a == '0);
            end
        end
    end
endmodule

// File: tb/tb_sub_abs_pipe.sv
// tb/tb_sub_abs_pipe.sv - self-checking bench for sub_abs_pipe at widths 74 and 8
module tb_sub_abs_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sub_abs_pipe_if #(.width(74)) b74();
    sub_abs_pipe_if #(.width(8))  b8();

    sub_abs_pipe #(.width(74)) dut74 (.clk(clk), .rst(rst), .bus(b74));
    sub_abs_pipe #(.width(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    int checks = 0;
    int errors = 0;

    logic [75:0] q74[$];
    logic [9:0]  q8[$];
    int acc74 = 0, acc8 = 0, pops74 = 0, pops8 = 0;
    logic        stall74 = 1'b0, stall8 = 1'b0;
    logic [75:0] held74;
    logic [9:0]  held8;

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [75:0] model74(input logic [73:0] a, input logic [73:0] b);
        if (a >= b) return {a - b, 1'b0, a == b};
        return {b - a, 1'b1, 1'b0};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b);
        if (a >= b) return {a - b, 1'b0, a == b};
        return {b - a, 1'b1, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q74.delete();
            stall74 = 1'b0;
        end else begin
            if (b74.in_valid && b74.in_ready) begin
                q74.push_back(model74(b74.in1, b74.in2));
                acc74++;
            end
            if (stall74 && b74.out_valid)
                check("hold74", {b74.res, b74.swap, b74.zero}, held74);
            if (b74.out_valid && b74.out_ready) begin
                if (q74.size() == 0)
                    check("spurious74", 76'(b74.out_valid), 76'd0);
                else begin
                    check("stream74", {b74.res, b74.swap, b74.zero}, q74.pop_front());
                    pops74++;
                end
            end
            stall74 = b74.out_valid && !b74.out_ready;
            held74  = {b74.res, b74.swap, b74.zero};
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            stall8 = 1'b0;
        end else begin
            if (b8.in_valid && b8.in_ready) begin
                q8.push_back(model8(b8.in1, b8.in2));
                acc8++;
            end
            if (stall8 && b8.out_valid)
                check("hold8", 76'({b8.res, b8.swap, b8.zero}), 76'(held8));
            if (b8.out_valid && b8.out_ready) begin
                if (q8.size() == 0)
                    check("spurious8", 76'(b8.out_valid), 76'd0);
                else begin
                    check("stream8", 76'({b8.res, b8.swap, b8.zero}), 76'(q8.pop_front()));
                    pops8++;
                end
            end
            stall8 = b8.out_valid && !b8.out_ready;
            held8  = {b8.res, b8.swap, b8.zero};
        end
    end

    task automatic push74(input logic [73:0] a, input logic [73:0] b);
        int n;
        @(posedge clk); #1;
        b74.in_valid = 1'b1;
        b74.in1 = a;
        b74.in2 = b;
        n = 0;
        @(negedge clk);
        while (!b74.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("push74_ready", 76'(b74.in_ready), 76'd1);
        @(posedge clk); #1;
        b74.in_valid = 1'b0;
    endtask

    task automatic expect74(input string name, input logic [73:0] r, input logic s, input logic z);
        int n;
        n = 0;
        @(negedge clk);
        while (!b74.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 76'(b74.out_valid), 76'd1);
        check(name, {b74.res, b74.swap, b74.zero}, {r, s, z});
    endtask

    logic [73:0] all1, p37, bpa[4], bpb[4];
    logic [95:0] r1, r2;
    int idx, base, base8, n;

    initial begin
        all1 = '1;
        p37  = 74'd1 << 37;
        rst  = 1'b1;
        b74.in_valid = 1'b0; b74.in1 = '0; b74.in2 = '0; b74.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.in1  = '0; b8.in2  = '0; b8.out_ready  = 1'b1;

        check("model_42",   model74(74'd100, 74'd58), {74'd42, 1'b0, 1'b0});
        check("model_swap", model74(74'd5, 74'd9),    {74'd4, 1'b1, 1'b0});
        check("model_eq",   model74(74'd7, 74'd7),    {74'd0, 1'b0, 1'b1});
        check("model8_ext", 76'(model8(8'd0, 8'hFF)), 76'({8'hFF, 1'b1, 1'b0}));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 76'(b74.out_valid), 76'd0);
        check("rst_outputs", {b74.res, b74.swap, b74.zero}, 76'd0);
        check("rst_in_ready", 76'(b74.in_ready), 76'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        push74(74'd100, 74'd58);
        @(negedge clk);
        check("lat_empty", 76'(b74.out_valid), 76'd0);
        check("lat_ready", 76'(b74.in_ready), 76'd1);
        @(negedge clk);
        check("lat_valid", 76'(b74.out_valid), 76'd1);
        check("single_op", {b74.res, b74.swap, b74.zero}, {74'd42, 1'b0, 1'b0});
        check("lat_ready2", 76'(b74.in_ready), 76'd1);

        push74(74'd5, 74'd9);     expect74("swap",     74'd4, 1'b1, 1'b0);
        push74(74'd0, all1);      expect74("extreme",  all1, 1'b1, 1'b0);
        push74(74'd7, 74'd7);     expect74("equal",    74'd0, 1'b0, 1'b1);
        push74(p37, 74'd1);       expect74("split",    p37 - 74'd1, 1'b0, 1'b0);
        push74(74'd1, p37);       expect74("split_rev", p37 - 74'd1, 1'b1, 1'b0);

        // Back-pressure: only two pairs fit while the consumer is stalled.
        bpa[0] = 74'd1000; bpb[0] = 74'd1;
        bpa[1] = 74'd3;    bpb[1] = 74'd20;
        bpa[2] = 74'd50;   bpb[2] = 74'd50;
        bpa[3] = 74'd1 << 73; bpb[3] = 74'd5;
        repeat (3) @(posedge clk);
        base = pops74;
        idx = 0;
        b74.out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            b74.in_valid = (idx < 4);
            b74.in1 = bpa[idx < 4 ? idx : 0];
            b74.in2 = bpb[idx < 4 ? idx : 0];
            @(negedge clk);
            if (b74.in_valid && b74.in_ready) idx++;
        end
        check("bp_accepted", 76'(idx), 76'd2);
        check("bp_in_ready", 76'(b74.in_ready), 76'd0);
        check("bp_out_valid", 76'(b74.out_valid), 76'd1);
        check("bp_head", {b74.res, b74.swap, b74.zero}, {74'd999, 1'b0, 1'b0});
        n = 0;
        while (idx < 4 && n < 20) begin
            @(posedge clk); #1;
            b74.out_ready = 1'b1;
            b74.in_valid = (idx < 4);
            b74.in1 = bpa[idx < 4 ? idx : 0];
            b74.in2 = bpb[idx < 4 ? idx : 0];
            @(negedge clk);
            if (b74.in_valid && b74.in_ready) idx++;
            n++;
        end
        @(posedge clk); #1;
        b74.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("bp_drained", 76'(pops74 - base), 76'd4);

        // Reset with two pairs in flight.
        b74.out_ready = 1'b0;
        push74(74'd11, 74'd3);
        push74(74'd2, 74'd30);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 76'(b74.out_valid), 76'd0);
        check("mid_rst_res", 76'(b74.res), 76'd0);
        check("mid_rst_ready", 76'(b74.in_ready), 76'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        b74.out_ready = 1'b1;
        base = pops74;
        repeat (5) @(negedge clk);
        check("no_stale", 76'(pops74 - base), 76'd0);
        push74(74'd12, 74'd40);
        expect74("after_rst", 74'd28, 1'b1, 1'b0);

        // Random traffic on both widths concurrently.
        @(posedge clk);
        base = acc74; base8 = acc8;
        for (int cyc = 0; cyc < 60000 && (acc74 - base < 10000 || acc8 - base8 < 10000); cyc++) begin
            @(posedge clk); #1;
            r1 = {$urandom, $urandom, $urandom};
            r2 = {$urandom, $urandom, $urandom};
            b74.in_valid  = (acc74 - base < 10000) && ($urandom_range(0, 1) == 1);
            b74.in1       = r1[73:0];
            b74.in2       = r2[73:0];
            if ($urandom_range(0, 15) == 0) b74.in2 = b74.in1;
            else if ($urandom_range(0, 7) == 0) b74.in2[73:37] = b74.in1[73:37];
            b74.out_ready = ($urandom_range(0, 1) == 1);
            b8.in_valid   = (acc8 - base8 < 10000) && ($urandom_range(0, 1) == 1);
            b8.in1        = r1[81:74];
            b8.in2        = ($urandom_range(0, 15) == 0) ? r1[81:74] : r2[81:74];
            b8.out_ready  = ($urandom_range(0, 1) == 1);
        end
        @(posedge clk); #1;
        b74.in_valid = 1'b0; b74.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.out_ready  = 1'b1;
        repeat (6) @(negedge clk);
        check("rand74_count", 76'(acc74 - base), 76'd10000);
        check("rand8_count",  76'(acc8 - base8), 76'd10000);
        check("rand74_drain", 76'(q74.size()), 76'd0);
        check("rand8_drain",  76'(q8.size()), 76'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
